// File: rtl/serial_regfile_port_if.sv
// Serial register-file port bundle: frame select, serial in/out, status.
// Master drives sel/sdi; slave returns sdo, done and frame_err.
interface serial_regfile_port_if;
  logic sel;
  logic sdi;
  logic sdo;
  logic done;
  logic frame_err;

  modport master (
    output sel,
    output sdi,
    input  sdo,
    input  done,
    input  frame_err
  );

  modport slave (
    input  sel,
    input  sdi,
    output sdo,
    output done,
    output frame_err
  );
endinterface

// File: rtl/serial_regfile_port.sv
// Framed bit-serial access port to a small register file.
// SERIAL_REGFILE_PARITY_EN adds an even-parity bit to write frames.
module serial_regfile_port #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_regfile_port_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
  localparam int CW    = $clog2(MAXW) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DIN,
    DOUT,
    DONE
`ifdef SERIAL_REGFILE_PARITY_EN
    ,PAR
`endif
  } state_t;

  logic [DATA_W-1:0] rf [DEPTH];

  state_t            st;
  logic              op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     cnt;
  logic              sdo_q;
  logic              done_q;
  logic              err_q;

  logic [ADDR_W:0]   addr_cat;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] word_nx;
  logic [DATA_W-1:0] rd_word;

  assign addr_cat = {addr, bus.sdi};
  assign addr_nx  = addr_cat[ADDR_W-1:0];
  assign word_nx  = {shreg[DATA_W-2:0], bus.sdi};
  assign rd_word  = rf[addr_nx];

  assign bus.sdo       = sdo_q;
  assign bus.done      = done_q;
  assign bus.frame_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= DONE;
      op     <= 1'b0;
      addr   <= '0;
      shreg  <= '0;
      cnt    <= '0;
      sdo_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (!bus.sel) begin
        // Dropping sel mid-frame discards the frame.
        sdo_q <= 1'b0;
        cnt   <= '0;
        if (st != IDLE && st != DONE) begin
          err_q <= 1'b1;
        end
        st <= IDLE;
      end else begin
        unique case (st)
          IDLE: begin
            op    <= bus.sdi;
            err_q <= 1'b0;
            cnt   <= '0;
            st    <= ADDR;
          end
          ADDR: begin
            addr <= addr_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == CW'(ADDR_W - 1)) begin
              cnt <= '0;
              if (op) begin
                st <= DIN;
              end else begin
                // First read bit goes out with the load.
                sdo_q <= rd_word[DATA_W-1];
                shreg <= {rd_word[DATA_W-2:0], 1'b0};
                st    <= DOUT;
              end
            end
          end
          DOUT: begin
            sdo_q <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) begin
              sdo_q  <= 1'b0;
              done_q <= 1'b1;
              cnt    <= '0;
              st     <= DONE;
            end
          end
          DIN: begin
            shreg <= word_nx;
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(DATA_W - 1)) begin
              cnt <= '0;
`ifdef SERIAL_REGFILE_PARITY_EN
              st <= PAR;
`else
              rf[addr] <= word_nx;
              done_q   <= 1'b1;
              st       <= DONE;
`endif
            end
          end
`ifdef SERIAL_REGFILE_PARITY_EN
          PAR: begin
            if (^{shreg, bus.sdi} == 1'b0) begin
              rf[addr] <= shreg;
              done_q   <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            st <= DONE;
          end
`endif
          DONE: begin
            sdo_q <= 1'b0;
          end
          default: begin
            st <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_regfile_port.sv
// Directed bench for serial_regfile_port (64-bit data, 8 registers).
// Inputs change after the falling edge; outputs are sampled there too.
module tb_serial_regfile_port;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_regfile_port_if bus ();

  serial_regfile_port #(
    .DATA_W(64),
    .ADDR_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bit_cyc(input logic s, input logic d);
    bus.sel = s;
    bus.sdi = d;
    @(posedge clk);
    @(negedge clk);
    done_cnt += int'(bus.done);
  endtask

  task automatic write_word(input logic [2:0]  a,
                            input logic [63:0] w,
                            input int          n_data,
                            input int          extra,
                            input logic        bad_par);
    bit_cyc(1'b1, 1'b1);
    for (int i = 2; i >= 0; i--) bit_cyc(1'b1, a[i]);
    for (int i = 0; i < n_data; i++) bit_cyc(1'b1, w[63-i]);
`ifdef SERIAL_REGFILE_PARITY_EN
    if (n_data == 64) bit_cyc(1'b1, (^w) ^ bad_par);
`else
    if (bad_par) bus.sdi = 1'b0;
`endif
    for (int i = 0; i < extra; i++) begin
      bit_cyc(1'b1, i[0]);
      check("extra_sdo", {63'd0, bus.sdo}, 64'd0);
    end
    bit_cyc(1'b0, 1'b0);
  endtask

  task automatic read_word(input  logic [2:0]  a,
                           output logic [63:0] w);
    w = '0;
    bit_cyc(1'b1, 1'b0);
    check("rd_err_clr", {63'd0, bus.frame_err}, 64'd0);
    for (int i = 2; i >= 0; i--) bit_cyc(1'b1, a[i]);
    for (int i = 0; i < 64; i++) begin
      w = {w[62:0], bus.sdo};
      bit_cyc(1'b1, i[1]);
    end
    check("rd_tail_sdo", {63'd0, bus.sdo}, 64'd0);
    check("rd_tail_done", {63'd0, bus.done}, 64'd1);
    bit_cyc(1'b0, 1'b0);
  endtask

  logic [63:0] rd;

  initial begin
    rst_n   = 1'b0;
    bus.sel = 1'b0;
    bus.sdi = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_sdo", {63'd0, bus.sdo}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_err", {63'd0, bus.frame_err}, 64'd0);
    rst_n = 1'b1;
    bit_cyc(1'b0, 1'b0);

    // Write then read back-to-back.
    done_cnt = 0;
    write_word(3'd5, 64'hDEAD_BEEF_0123_4567, 64, 0, 1'b0);
    check("t1_wr_done", 64'(done_cnt), 64'd1);
    done_cnt = 0;
    read_word(3'd5, rd);
    check("t1_rd_data", rd, 64'hDEAD_BEEF_0123_4567);
    check("t1_rd_done", 64'(done_cnt), 64'd1);

    // Reset with sel held high, then sel stays high.
    bus.sel = 1'b1;
    bus.sdi = 1'b1;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) bit_cyc(1'b1, ~i[0]);
    check("t2_done", 64'(done_cnt), 64'd0);
    check("t2_err", {63'd0, bus.frame_err}, 64'd0);
    check("t2_sdo", {63'd0, bus.sdo}, 64'd0);
    bit_cyc(1'b0, 1'b0);
    check("t2_err_idle", {63'd0, bus.frame_err}, 64'd0);
    for (int a = 0; a < 8; a++) begin
      read_word(3'(a), rd);
      check($sformatf("t2_rf%0d", a), rd, 64'd0);
    end
    done_cnt = 0;
    write_word(3'd1, 64'h0123_4567_89AB_CDEF, 64, 0, 1'b0);
    read_word(3'd1, rd);
    check("t2_after", rd, 64'h0123_4567_89AB_CDEF);
    check("t2_after_done", 64'(done_cnt), 64'd2);

    // Abort a write after 30 data bits.
    done_cnt = 0;
    write_word(3'd2, '1, 30, 0, 1'b0);
    check("t3_err", {63'd0, bus.frame_err}, 64'd1);
    check("t3_done", 64'(done_cnt), 64'd0);
    read_word(3'd2, rd);
    check("t3_rf2", rd, 64'd0);

    // Highest address, no aliasing onto address 0.
    write_word(3'd7, 64'h1, 64, 0, 1'b0);
    read_word(3'd0, rd);
    check("t4_rf0", rd, 64'd0);
    read_word(3'd7, rd);
    check("t4_rf7", rd, 64'd1);

    // Overwrite the same address.
    write_word(3'd3, 64'h3, 64, 0, 1'b0);
    done_cnt = 0;
`ifdef SERIAL_REGFILE_PARITY_EN
    write_word(3'd3, 64'h1, 64, 0, 1'b1);
    check("t5_err", {63'd0, bus.frame_err}, 64'd1);
    check("t5_done", 64'(done_cnt), 64'd0);
    read_word(3'd3, rd);
    check("t5_rf3", rd, 64'h3);
`else
    write_word(3'd3, 64'hA5A5_0000_FFFF_5A5A, 64, 0, 1'b0);
    check("t5_done", 64'(done_cnt), 64'd1);
    read_word(3'd3, rd);
    check("t5_rf3", rd, 64'hA5A5_0000_FFFF_5A5A);
`endif

    // Extra bits after a complete write.
    done_cnt = 0;
    write_word(3'd6, 64'hCAFE_F00D_1234_8765, 64, 10, 1'b0);
    check("t6_done", 64'(done_cnt), 64'd1);
    check("t6_err", {63'd0, bus.frame_err}, 64'd0);
    read_word(3'd6, rd);
    check("t6_rf6", rd, 64'hCAFE_F00D_1234_8765);

    // Abort a read mid-stream.
    done_cnt = 0;
    bit_cyc(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bit_cyc(1'b1, 1'b1);
    repeat (5) bit_cyc(1'b1, 1'b0);
    bit_cyc(1'b0, 1'b0);
    check("t7_err", {63'd0, bus.frame_err}, 64'd1);
    check("t7_done", 64'(done_cnt), 64'd0);
    check("t7_sdo", {63'd0, bus.sdo}, 64'd0);

    // Reset mid-write clears the file.
    bit_cyc(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) bit_cyc(1'b1, 1'b1);
    repeat (10) bit_cyc(1'b1, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t8_err", {63'd0, bus.frame_err}, 64'd0);
    rst_n = 1'b1;
    bit_cyc(1'b0, 1'b0);
    read_word(3'd7, rd);
    check("t8_rf7", rd, 64'd0);
    read_word(3'd6, rd);
    check("t8_rf6", rd, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
